// File: rtl/commit_trace_monitor.sv
// Debug commit-port consumer: pc sequence checking, commit history ring buffer,
// retirement counter, ebreak halt detection and a commit watchdog.
module commit_trace_monitor #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      DEPTH       = 16,
  parameter int unsigned      WDOG_CYCLES = 1024,
  parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(32'h80000000)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     debug_valid,
  input  logic [WIDTH-1:0]         debug_pc,
  input  logic [WIDTH-1:0]         debug_inst,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_pc,
  output logic [WIDTH-1:0]         rd_inst,
  output logic [$clog2(DEPTH):0]   buf_count,
  output logic                     overflow,
  output logic [63:0]              commit_cnt,
  output logic                     halt,
  output logic [WIDTH-1:0]         halt_pc,
  output logic                     wdog_timeout,
  output logic                     seq_err,
  output logic [WIDTH-1:0]         err_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WIDTH-1:0] Ebreak = WIDTH'(32'h00100073);

  typedef enum logic [1:0] {StRun, StHalted, StTimeout} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mem_q [DEPTH];
  logic [2*WIDTH-1:0]   mem_d [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]     rd_pc_q, rd_pc_d, rd_inst_q, rd_inst_d;
  logic [63:0]          commit_cnt_q, commit_cnt_d;
  logic                 halt_q, halt_d;
  logic [WIDTH-1:0]     halt_pc_q, halt_pc_d;
  logic [WW-1:0]        wdog_q, wdog_d;
  logic                 wdog_timeout_q, wdog_timeout_d;
  logic                 seq_err_q, seq_err_d;
  logic [WIDTH-1:0]     err_pc_q, err_pc_d;
  logic [WIDTH-1:0]     prev_pc_q, prev_pc_d;
  logic                 prev_jump_q, prev_jump_d;
  logic                 first_q, first_d;

  logic          accept, pop, full, seq_ok, cur_jump;
  logic [WW-1:0] wdog_inc;

  assign accept   = debug_valid && (state_q == StRun);
  assign pop      = rd_en && (count_q != '0);
  assign full     = (count_q == CW'(DEPTH));
  assign wdog_inc = wdog_q + WW'(1);
  assign cur_jump = (debug_inst[6:0] == 7'b1101111) || (debug_inst[6:0] == 7'b1100111) ||
                    (debug_inst[6:0] == 7'b1100011);
  // After a control-transfer instruction only alignment can be checked.
  assign seq_ok   = first_q     ? (debug_pc == RESET_PC) :
                    prev_jump_q ? (debug_pc[1:0] == 2'b00) :
                                  (debug_pc == prev_pc_q + WIDTH'(4));

  always_comb begin
    state_d        = state_q;
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    overflow_d     = overflow_q;
    rd_valid_d     = pop;
    rd_pc_d        = rd_pc_q;
    rd_inst_d      = rd_inst_q;
    commit_cnt_d   = commit_cnt_q;
    halt_d         = halt_q;
    halt_pc_d      = halt_pc_q;
    wdog_d         = wdog_q;
    wdog_timeout_d = wdog_timeout_q;
    seq_err_d      = seq_err_q;
    err_pc_d       = err_pc_q;
    prev_pc_d      = prev_pc_q;
    prev_jump_d    = prev_jump_q;
    first_d        = first_q;

    if (pop) begin
      {rd_pc_d, rd_inst_d} = mem_q[rd_ptr_q];
      rd_ptr_d             = rd_ptr_q + PW'(1);
    end

    if (accept) begin
      mem_d[wr_ptr_q] = {debug_pc, debug_inst};
      wr_ptr_d        = wr_ptr_q + PW'(1);
      // Full without a pop: the oldest entry is dropped to make room.
      if (full && !pop) begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
        overflow_d = 1'b1;
      end else if (!pop) begin
        count_d = count_q + CW'(1);
      end
      commit_cnt_d = commit_cnt_q + 64'd1;
      wdog_d       = '0;
      prev_pc_d    = debug_pc;
      prev_jump_d  = cur_jump;
      first_d      = 1'b0;
      if (!seq_ok) begin
        seq_err_d = 1'b1;
        if (!seq_err_q) err_pc_d = debug_pc;
      end
      if (debug_inst == Ebreak) begin
        state_d   = StHalted;
        halt_d    = 1'b1;
        halt_pc_d = debug_pc;
      end
    end else begin
      if (pop) count_d = count_q - CW'(1);
      if (state_q == StRun) begin
        wdog_d = wdog_inc;
        if (wdog_inc == WW'(WDOG_CYCLES)) begin
          state_d        = StTimeout;
          wdog_timeout_d = 1'b1;
        end
      end
    end

    if (clr) begin
      state_d        = StRun;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      overflow_d     = 1'b0;
      rd_valid_d     = 1'b0;
      rd_pc_d        = '0;
      rd_inst_d      = '0;
      commit_cnt_d   = '0;
      halt_d         = 1'b0;
      halt_pc_d      = '0;
      wdog_d         = '0;
      wdog_timeout_d = 1'b0;
      seq_err_d      = 1'b0;
      err_pc_d       = '0;
      prev_pc_d      = '0;
      prev_jump_d    = 1'b0;
      first_d        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StRun;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_pc_q        <= '0;
      rd_inst_q      <= '0;
      commit_cnt_q   <= '0;
      halt_q         <= 1'b0;
      halt_pc_q      <= '0;
      wdog_q         <= '0;
      wdog_timeout_q <= 1'b0;
      seq_err_q      <= 1'b0;
      err_pc_q       <= '0;
      prev_pc_q      <= '0;
      prev_jump_q    <= 1'b0;
      first_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      rd_valid_q     <= rd_valid_d;
      rd_pc_q        <= rd_pc_d;
      rd_inst_q      <= rd_inst_d;
      commit_cnt_q   <= commit_cnt_d;
      halt_q         <= halt_d;
      halt_pc_q      <= halt_pc_d;
      wdog_q         <= wdog_d;
      wdog_timeout_q <= wdog_timeout_d;
      seq_err_q      <= seq_err_d;
      err_pc_q       <= err_pc_d;
      prev_pc_q      <= prev_pc_d;
      prev_jump_q    <= prev_jump_d;
      first_q        <= first_d;
    end
  end

  // Storage needs no reset; count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_valid     = rd_valid_q;
  assign rd_pc        = rd_pc_q;
  assign rd_inst      = rd_inst_q;
  assign buf_count    = count_q;
  assign overflow     = overflow_q;
  assign commit_cnt   = commit_cnt_q;
  assign halt         = halt_q;
  assign halt_pc      = halt_pc_q;
  assign wdog_timeout = wdog_timeout_q;
  assign seq_err      = seq_err_q;
  assign err_pc       = err_pc_q;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Scoreboard bench for commit_trace_monitor: queue-based reference model, directed
// scenarios followed by randomized commit/pop/clear traffic.
module tb_commit_trace_monitor;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 16;
  localparam int unsigned WD = 8;
  localparam logic [31:0] RPC = 32'h80000000;
  localparam logic [31:0] EBRK = 32'h00100073;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk, rst, clr, debug_valid, rd_en;
  logic [31:0] debug_pc, debug_inst;
  logic        rd_valid, overflow, halt, wdog_timeout, seq_err;
  logic [31:0] rd_pc, rd_inst, halt_pc, err_pc;
  logic [4:0]  buf_count;
  logic [63:0] commit_cnt;

  commit_trace_monitor #(
    .WIDTH(W), .DEPTH(D), .WDOG_CYCLES(WD), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .debug_valid(debug_valid), .debug_pc(debug_pc),
    .debug_inst(debug_inst), .rd_en(rd_en), .rd_valid(rd_valid), .rd_pc(rd_pc),
    .rd_inst(rd_inst), .buf_count(buf_count), .overflow(overflow),
    .commit_cnt(commit_cnt), .halt(halt), .halt_pc(halt_pc), .wdog_timeout(wdog_timeout),
    .seq_err(seq_err), .err_pc(err_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  ent_t        hist[$];
  ent_t        exp_q[$];
  logic [63:0] m_cnt;
  logic        m_ovf, m_halt, m_to, m_seq, m_first, m_popped;
  logic [31:0] m_halt_pc, m_err_pc, m_prev_pc, m_prev_inst, m_rd_pc, m_rd_inst;
  int          m_idle;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_cnt = 0; m_ovf = 0; m_halt = 0; m_to = 0; m_seq = 0; m_first = 1; m_popped = 0;
    m_halt_pc = 0; m_err_pc = 0; m_prev_pc = 0; m_prev_inst = 0; m_idle = 0;
    m_rd_pc = 0; m_rd_inst = 0;
  endtask

  function automatic logic is_ctl(input logic [31:0] inst);
    return inst[6:0] == 7'b1101111 || inst[6:0] == 7'b1100111 || inst[6:0] == 7'b1100011;
  endfunction

  task automatic model_step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                            input logic rd, input logic c);
    ent_t e;
    logic bad;
    if (c) begin
      model_reset();
      return;
    end
    m_popped = 0;
    if (rd && hist.size() > 0) begin
      e = hist.pop_front();
      exp_q.push_back(e);
      m_popped = 1; m_rd_pc = e.pc; m_rd_inst = e.inst;
    end
    if (v && !m_halt && !m_to) begin
      if (m_first) bad = (pc != RPC);
      else if (is_ctl(m_prev_inst)) bad = (pc[1:0] != 2'b00);
      else bad = (pc != m_prev_pc + 32'd4);
      if (bad && !m_seq) m_err_pc = pc;
      if (bad) m_seq = 1;
      m_first = 0; m_prev_pc = pc; m_prev_inst = inst;
      m_cnt = m_cnt + 64'd1;
      e.pc = pc; e.inst = inst;
      hist.push_back(e);
      if (hist.size() > D) begin
        void'(hist.pop_front());
        m_ovf = 1;
      end
      m_idle = 0;
      if (inst == EBRK) begin
        m_halt = 1; m_halt_pc = pc;
      end
    end else if (!m_halt && !m_to) begin
      m_idle++;
      if (m_idle == WD) m_to = 1;
    end
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic rd, input logic c);
    debug_valid = v; debug_pc = pc; debug_inst = inst; rd_en = rd; clr = c;
    model_step(v, pc, inst, rd, c);
    @(posedge clk);
    #1;
    debug_valid = 0; rd_en = 0; clr = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".commit_cnt"}, commit_cnt, m_cnt);
    chk({tag, ".buf_count"}, 64'(buf_count), 64'(hist.size()));
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".halt"}, 64'(halt), 64'(m_halt));
    chk({tag, ".halt_pc"}, 64'(halt_pc), 64'(m_halt_pc));
    chk({tag, ".wdog_timeout"}, 64'(wdog_timeout), 64'(m_to));
    chk({tag, ".seq_err"}, 64'(seq_err), 64'(m_seq));
    chk({tag, ".err_pc"}, 64'(err_pc), 64'(m_err_pc));
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(m_popped));
    chk({tag, ".rd_pc_hold"}, 64'(rd_pc), 64'(m_rd_pc));
    chk({tag, ".rd_inst_hold"}, 64'(rd_inst), 64'(m_rd_inst));
  endtask

  task automatic monitor();
    ent_t e;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("rd_valid_unexpected", 64'(rd_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb.rd_pc", 64'(rd_pc), 64'(e.pc));
          chk("sb.rd_inst", 64'(rd_inst), 64'(e.inst));
        end
      end
    end
  endtask

  logic [31:0] insts[5];
  logic [31:0] cur_pc, ipc, iinst;

  initial begin
    insts[0] = NOP; insts[1] = 32'h0000006F; insts[2] = 32'h00008067;
    insts[3] = 32'h00000063; insts[4] = 32'h00A00093;
    rst = 1; clr = 0; debug_valid = 0; debug_pc = 0; debug_inst = 0; rd_en = 0;
    model_reset();
    fork
      monitor();
    join_none
    #2;
    check_all("reset");
    #10 rst = 0;
    @(posedge clk); #1;

    // Straight-line commits then drain
    for (int i = 0; i < 5; i++) step(1, RPC + 32'(4 * i), NOP, 0, 0);
    check_all("straight");
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0);
      check_all("drain");
    end
    step(0, 0, 0, 1, 0);
    check_all("pop_empty");

    // Sequence errors: first error latched, later ones leave err_pc alone
    step(0, 0, 0, 0, 1);
    step(1, RPC, NOP, 0, 0);
    step(1, RPC + 32'h8, 32'h0000006F, 0, 0);
    check_all("seq_first_err");
    step(1, RPC + 32'h100, NOP, 0, 0);
    step(1, RPC + 32'h200, 32'h00000063, 0, 0);
    step(1, RPC + 32'h302, NOP, 0, 0);
    check_all("seq_later");

    // Overflow and push+pop while full
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, RPC + 32'(4 * i), NOP, 0, 0);
    check_all("overflow");
    step(1, RPC + 32'(4 * 20), NOP, 1, 0);
    check_all("full_push_pop");
    step(0, 0, 0, 1, 0);
    check_all("after_full_pop");

    // ebreak halt, ignored commit, pop while halted, clear
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, RPC + 32'(4 * i), NOP, 0, 0);
    step(1, RPC + 32'hC, EBRK, 0, 0);
    check_all("halt");
    step(1, RPC + 32'h10, NOP, 0, 0);
    step(0, 0, 0, 1, 0);
    check_all("halted_ignore");
    step(0, 0, 0, 0, 1);
    check_all("halt_clr");

    // Watchdog
    step(1, RPC, NOP, 0, 0);
    for (int i = 0; i < WD - 1; i++) step(0, 0, 0, 0, 0);
    check_all("wdog_pre");
    step(0, 0, 0, 0, 0);
    check_all("wdog_fire");
    step(1, RPC + 32'h4, NOP, 0, 0);
    check_all("wdog_ignore");
    step(0, 0, 0, 0, 1);
    step(1, RPC, NOP, 0, 0);
    for (int i = 0; i < WD - 2; i++) step(0, 0, 0, 0, 0);
    step(1, RPC + 32'h4, NOP, 0, 0);
    for (int i = 0; i < WD - 2; i++) step(0, 0, 0, 0, 0);
    check_all("wdog_rescue");

    // Randomized traffic
    step(0, 0, 0, 0, 1);
    cur_pc = RPC - 32'd4;
    for (int n = 0; n < 600; n++) begin
      int r;
      logic v, rd, c;
      r = int'($urandom_range(0, 9));
      if (r < 7) ipc = cur_pc + 32'd4;
      else if (r == 7) ipc = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      else if (r == 8) ipc = cur_pc + 32'd8;
      else ipc = $urandom;
      iinst = ($urandom_range(0, 59) == 0) ? EBRK : insts[$urandom_range(0, 4)];
      v  = ($urandom_range(0, 9) < 6);
      rd = ($urandom_range(0, 9) < 4);
      c  = ($urandom_range(0, 149) == 0) || ((m_halt || m_to) && $urandom_range(0, 7) == 0);
      if (c) cur_pc = RPC - 32'd4;
      else if (v) cur_pc = ipc;
      step(v, ipc, iinst, rd, c);
      check_all("rand");
    end

    // Asynchronous reset between edges
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, RPC + 32'(4 * i), NOP, 0, 0);
    check_all("pre_async");
    #3 rst = 1;
    #1;
    model_reset();
    exp_q.delete();
    check_all("async_rst");
    #1 rst = 0;
    step(1, RPC, NOP, 0, 0);
    check_all("post_async");

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("sb.drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_trace_monitor.md
Name: commit_trace_monitor

Overview:
- Consumer end of the CPU debug commit interface.
- Samples each retired instruction's pc and instruction word, and checks the pc sequence.
- Keeps a history ring buffer of the last DEPTH commits, counts retirements, and detects ebreak (halt) and stalls (watchdog).
- Sits beside the CPU core at top level; drives status to the simulation harness and SoC debug logic.

Parameters:
- WIDTH, 32, pc/instruction width.
- DEPTH, 16, ring-buffer entries; power of two, at least 2.
- WDOG_CYCLES, 1024, commit-free cycles in RUN before timeout.
- RESET_PC, 32'h80000000, expected pc of the first commit after reset/clr.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- clr  input  1  synchronous clear of all state; same effect as reset
- debug_valid  input  1  one instruction retires this cycle
- debug_pc  input  WIDTH  pc of the retiring instruction
- debug_inst  input  WIDTH  retiring instruction word
- rd_en  input  1  pop oldest buffer entry
- rd_valid  output  1  rd_pc/rd_inst valid; one-cycle pulse
- rd_pc  output  WIDTH  popped pc
- rd_inst  output  WIDTH  popped instruction
- buf_count  output  $clog2(DEPTH)+1  entries held
- overflow  output  1  sticky; an entry was overwritten
- commit_cnt  output  64  total accepted commits
- halt  output  1  ebreak retired
- halt_pc  output  WIDTH  pc of that ebreak
- wdog_timeout  output  1  watchdog fired
- seq_err  output  1  sticky pc-sequence error
- err_pc  output  WIDTH  pc of the first offending commit

Behaviour:
- One clock: clk. Reset is asynchronous and active-high on rst.
- Reset and clr clear everything:
  - all outputs 0; buffer empty; pointers 0; watchdog 0;
  - expected pc = RESET_PC; first-commit flag = 1; state = RUN.
- clr takes priority over a same-cycle debug_valid or rd_en; that commit/pop is dropped.
- States:
  - RUN to HALTED: cycle after an accepted commit with debug_inst == 32'h00100073.
  - RUN to TIMEOUT: watchdog reaches WDOG_CYCLES.
  - HALTED and TIMEOUT are left only by rst/clr.
- Commit acceptance:
  - debug_valid in RUN = accepted.
  - debug_valid in HALTED/TIMEOUT is ignored: no push, no count, no checks.
  - Buffer reads still work in all states.
- Accepted commit, effects visible next cycle:
  - commit_cnt += 1, wrapping at 2^64.
  - {pc, inst} pushed to the ring buffer.
  - watchdog cleared.
- ebreak: the ebreak commit itself is pushed and counted. halt=1 and halt_pc latched on the next edge.
- Watchdog:
  - In RUN, increments each cycle without an accepted commit.
  - When the count equals WDOG_CYCLES, wdog_timeout=1 and state = TIMEOUT on the next edge.
  - Does not count in HALTED.
- Sequence check, per accepted commit:
  - First commit after reset/clr: must equal RESET_PC.
  - Otherwise, if the previous inst opcode[6:0] is 1101111 (JAL), 1100111 (JALR) or 1100011 (BRANCH): only require pc[1:0]==0.
  - Otherwise: pc must equal previous pc + 4, modulo 2^WIDTH.
  - On failure: seq_err=1 (sticky). err_pc latched only on the first failure.
  - Checking continues after an error.
- Ring buffer:
  - push, not full: write at wr_ptr; count+1.
  - push, full, no pop: overwrite oldest; advance both pointers; count stays DEPTH; overflow=1.
  - rd_en, not empty: rd_pc/rd_inst = oldest entry, rd_valid=1 on the next cycle (registered, 1-cycle latency); count-1.
  - rd_en, empty: ignored; rd_valid=0; outputs hold their last value.
  - push and pop in the same cycle, including when full: pop returns the pre-push oldest; push goes into the freed slot; count unchanged; no overflow.
  - Pointers wrap modulo DEPTH.
- Reset asserted mid-operation: all state is cleared immediately (asynchronous). Entries that were not yet read are lost.

Test Plan:
- Straight-line: after reset, 5 commits at pc 0x80000000, 04, 08, 0C, 10 with inst 0x00000013 -> commit_cnt=5, buf_count=5, seq_err=0. Then 5 pops -> rd_pc 0x80000000..0x80000010 in order, 1-cycle latency, buf_count=0.
- Sequence error: commits at 0x80000000 then 0x80000008 (previous inst is addi) -> seq_err=1, err_pc=0x80000008. A later jump 0x0000006F followed by 0x80000100 -> no new error, err_pc unchanged.
- Overflow/wrap: 20 commits with no reads, DEPTH=16 -> buf_count=16, overflow=1; the first pop returns commit #5. A push and pop together while full -> buf_count stays 16, overflow stays as is, the pop returns the pre-push oldest.
- ebreak: commit 0x00100073 at 0x8000000C -> halt=1, halt_pc=0x8000000C, commit_cnt includes it. A further debug_valid -> commit_cnt unchanged. clr -> halt=0, commit_cnt=0, state RUN.
- Watchdog (WDOG_CYCLES=8): 1 commit, then 8 idle cycles -> wdog_timeout=1. A later commit is ignored. A commit on idle cycle 7 instead -> no timeout.
- Async reset mid-run: assert rst between clock edges with buf_count=3, halt=0 -> all outputs 0 before the next edge. After release, the first commit must be at RESET_PC.
